// File: rtl/rc4_pkg.sv
// Shared types for the RC4 PRGA decrypt stage: byte type, S-box depth,
// the PRGA state encoding and the plaintext character rule.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int S_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    READ_F,
    WAIT_F,
    WRITE_OUT,
    DONE
  } prga_state_t;

  // Acceptable plaintext for key search: lowercase letters or space
  function automatic logic is_plain_char(byte_t b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Bus between the PRGA decrypt FSM and its surroundings: start/done control,
// the S memory port, the ciphertext ROM port and the plaintext RAM port.
// master = the PRGA engine, slave = the controller and memories.
interface rc4_prga_decrypt_if #(
  parameter int MSG_AW = 5
);
  import rc4_pkg::*;

  logic              start;
  logic              done;
  logic              bad_char;
  byte_t             s_addr;
  byte_t             s_wdata;
  logic              s_wren;
  byte_t             s_q;
  logic [MSG_AW-1:0] rom_addr;
  byte_t             rom_q;
  logic [MSG_AW-1:0] out_addr;
  byte_t             out_data;
  logic              out_wren;

  modport master (
    input  start, s_q, rom_q,
    output done, bad_char, s_addr, s_wdata, s_wren,
           rom_addr, out_addr, out_data, out_wren
  );

  modport slave (
    output start, s_q, rom_q,
    input  done, bad_char, s_addr, s_wdata, s_wren,
           rom_addr, out_addr, out_data, out_wren
  );

endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA decrypt engine. Walks the shuffled S memory, swaps S[i]/S[j],
// fetches the keystream byte S[S[i]+S[j]], XORs it with the ciphertext ROM
// and writes plaintext out; nine single-cycle states per message byte.
// Optional feature macro: RC4_PRGA_CHAR_CHECK_EN -- abort to DONE with
// bad_char set as soon as a decrypted byte is not 'a'..'z' or space.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  rc4_prga_decrypt_if.master bus
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  prga_state_t       state;
  byte_t             i, j, si, sj;
  logic [MSG_AW-1:0] k;

  byte_t             s_addr_q, s_wdata_q, out_data_q;
  logic              s_wren_q, out_wren_q, done_q;
  logic [MSG_AW-1:0] rom_addr_q, out_addr_q;
  logic              char_bad;

`ifdef RC4_PRGA_CHAR_CHECK_EN
  logic bad_q;
  assign char_bad     = !is_plain_char(out_data_q);
  assign bus.bad_char = bad_q;
`else
  assign char_bad     = 1'b0;
  assign bus.bad_char = 1'b0;
`endif

  assign bus.done     = done_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wren   = s_wren_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;
  assign bus.out_wren = out_wren_q;

  // PRGA sequencer: each state sets the registered memory outputs for the next one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      sj         <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wren_q   <= 1'b0;
      rom_addr_q <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_wren_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef RC4_PRGA_CHAR_CHECK_EN
      bad_q      <= 1'b0;
`endif
    end else begin
      s_wren_q   <= 1'b0;
      out_wren_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= READ_I;
            i        <= 8'd1;
            j        <= '0;
            k        <= '0;
            s_addr_q <= 8'd1;
            done_q   <= 1'b0;
`ifdef RC4_PRGA_CHAR_CHECK_EN
            bad_q    <= 1'b0;
`endif
          end
        end
        READ_I: state <= WAIT_I;
        WAIT_I: begin
          si       <= bus.s_q;
          j        <= j + bus.s_q;
          s_addr_q <= j + bus.s_q;
          state    <= READ_J;
        end
        READ_J: state <= WAIT_J;
        WAIT_J: begin
          sj        <= bus.s_q;
          s_addr_q  <= i;
          s_wdata_q <= bus.s_q;
          s_wren_q  <= 1'b1;
          state     <= WRITE_I;
        end
        WRITE_I: begin
          s_addr_q  <= j;
          s_wdata_q <= si;
          s_wren_q  <= 1'b1;
          state     <= WRITE_J;
        end
        WRITE_J: begin
          s_addr_q   <= si + sj;
          rom_addr_q <= k;
          state      <= READ_F;
        end
        READ_F: state <= WAIT_F;
        WAIT_F: begin
          out_addr_q <= k;
          out_data_q <= bus.s_q ^ bus.rom_q;
          out_wren_q <= 1'b1;
          state      <= WRITE_OUT;
        end
        WRITE_OUT: begin
          if (char_bad || (k == K_LAST)) begin
            state  <= DONE;
            done_q <= 1'b1;
`ifdef RC4_PRGA_CHAR_CHECK_EN
            bad_q  <= char_bad;
`endif
          end else begin
            k        <= k + MSG_AW'(1);
            i        <= i + 8'd1;
            s_addr_q <= i + 8'd1;
            state    <= READ_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: a 32-byte and a 512-byte instance
// with behavioural S memory, ciphertext ROM and plaintext RAM, checked against
// a plain software RC4 PRGA model. Honours RC4_PRGA_CHAR_CHECK_EN.
module tb_rc4_prga_decrypt;
  import rc4_pkg::*;

  localparam int LEN_A = 32;
  localparam int AW_A  = 5;
  localparam int LEN_B = 512;
  localparam int AW_B  = 9;
`ifdef RC4_PRGA_CHAR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    string name;
    bit    isS;
    int    idx;
    byte_t expected;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic loadS = 1'b0;
  int   checks = 0;
  int   failures = 0;

  byte_t initS[S_DEPTH];
  byte_t sMemA[S_DEPTH];
  byte_t sMemB[S_DEPTH];
  byte_t snapA[S_DEPTH];
  byte_t romA[LEN_A];
  byte_t romB[LEN_B];
  byte_t outA[LEN_A];
  byte_t outB[LEN_B];

  byte_t mS[S_DEPTH];
  byte_t mSnap[S_DEPTH];
  byte_t mRom[LEN_B];
  byte_t mOut[LEN_B];
  int    mBytes;
  bit    mBad;

  // Free-running clock
  always #5 clk = ~clk;

  rc4_prga_decrypt_if #(.MSG_AW(AW_A)) busA ();
  rc4_prga_decrypt_if #(.MSG_AW(AW_B)) busB ();

  rc4_prga_decrypt #(.MSG_LEN(LEN_A), .MSG_AW(AW_A)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(busA)
  );
  rc4_prga_decrypt #(.MSG_LEN(LEN_B), .MSG_AW(AW_B)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(busB)
  );

  // Memories for instance A: 1-cycle read latency, S reloadable from initS
  always @(posedge clk) begin
    if (loadS) sMemA <= initS;
    else if (busA.s_wren) sMemA[busA.s_addr] <= busA.s_wdata;
    busA.s_q   <= sMemA[busA.s_addr];
    busA.rom_q <= romA[busA.rom_addr];
    if (busA.out_wren) outA[busA.out_addr] <= busA.out_data;
  end

  // Memories for instance B
  always @(posedge clk) begin
    if (loadS) sMemB <= initS;
    else if (busB.s_wren) sMemB[busB.s_addr] <= busB.s_wdata;
    busB.s_q   <= sMemB[busB.s_addr];
    busB.rom_q <= romB[busB.rom_addr];
    if (busB.out_wren) outB[busB.out_addr] <= busB.out_data;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Textbook RC4 PRGA over the initial S, optionally stopping at the first bad character
  task automatic runModel(input int len, input bit useCheck);
    int    i, j;
    byte_t t, p;
    i = 0; j = 0;
    mS = initS;
    mBad = 1'b0;
    mBytes = 0;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(mS[i])) % 256;
      t = mS[i]; mS[i] = mS[j]; mS[j] = t;
      p = mS[(int'(mS[i]) + int'(mS[j])) % 256] ^ mRom[k];
      mOut[k] = p;
      mBytes = k + 1;
      if (k == 2) mSnap = mS;
      if (useCheck && !(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) begin
        mBad = 1'b1;
        break;
      end
    end
  endtask

  // Build S and ROM contents: 0 all-zero ROM, 1 clean lowercase plaintext,
  // 2 lowercase with one uppercase byte, 3 ROM[0]=0x02 only
  task automatic applyStimulus(input int mode, input bit randomS);
    int    r, pos;
    byte_t t, plain;
    for (int n = 0; n < S_DEPTH; n++) initS[n] = byte_t'(n);
    if (randomS) begin
      for (int n = S_DEPTH - 1; n > 0; n--) begin
        r = $urandom_range(n, 0);
        t = initS[n]; initS[n] = initS[r]; initS[r] = t;
      end
    end
    for (int n = 0; n < LEN_B; n++) mRom[n] = 8'h00;
    if (mode == 1 || mode == 2) begin
      runModel(LEN_B, 1'b0);
      pos = (mode == 2) ? $urandom_range(LEN_A - 1, 0) : -1;
      for (int n = 0; n < LEN_B; n++) begin
        r = $urandom_range(26, 0);
        plain = (r == 26) ? 8'h20 : byte_t'(8'h61 + r);
        if (n == pos) plain = byte_t'(8'h41 + $urandom_range(25, 0));
        mRom[n] = mOut[n] ^ plain;
      end
    end else if (mode == 3) begin
      mRom[0] = 8'h02;
    end
    for (int n = 0; n < LEN_A; n++) romA[n] = mRom[n];
    for (int n = 0; n < LEN_B; n++) romB[n] = mRom[n];
    @(negedge clk); loadS = 1'b1;
    @(negedge clk); loadS = 1'b0;
  endtask

  task automatic checkIdle(input bit useB, input string tag);
    if (useB) begin
      checkOutput({tag, "_done"}, busB.done, 0);
      checkOutput({tag, "_bad"}, busB.bad_char, 0);
      checkOutput({tag, "_s_addr"}, busB.s_addr, 0);
      checkOutput({tag, "_s_wren"}, busB.s_wren, 0);
      checkOutput({tag, "_rom_addr"}, busB.rom_addr, 0);
      checkOutput({tag, "_out_wren"}, busB.out_wren, 0);
    end else begin
      checkOutput({tag, "_done"}, busA.done, 0);
      checkOutput({tag, "_bad"}, busA.bad_char, 0);
      checkOutput({tag, "_s_addr"}, busA.s_addr, 0);
      checkOutput({tag, "_s_wdata"}, busA.s_wdata, 0);
      checkOutput({tag, "_s_wren"}, busA.s_wren, 0);
      checkOutput({tag, "_rom_addr"}, busA.rom_addr, 0);
      checkOutput({tag, "_out_addr"}, busA.out_addr, 0);
      checkOutput({tag, "_out_data"}, busA.out_data, 0);
      checkOutput({tag, "_out_wren"}, busA.out_wren, 0);
    end
  endtask

  // Pulse start, count edges until done; optional mid-run reset or start spam
  task automatic runDut(input bit useB, input int abortAt, input bit pokeStart,
                        output int edges, output int wrenCount);
    logic doneNow;
    edges = 0; wrenCount = 0;
    @(negedge clk);
    if (useB) busB.start = 1'b1; else busA.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0; busB.start = 1'b0;
    forever begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      busA.start = 1'b0;
      if ((useB ? busB.out_wren : busA.out_wren) == 1'b1) wrenCount++;
      if (!useB && busA.out_wren && busA.out_addr == 5'd2) snapA = sMemA;
      if (edges == abortAt) begin
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle(1'b0, "abort");
        reset_n = 1'b1;
        return;
      end
      doneNow = useB ? busB.done : busA.done;
      if (doneNow || edges > 6000) break;
      if (pokeStart && (edges % 5 == 2)) busA.start = 1'b1;
    end
    busA.start = 1'b0;
    checkOutput("done_seen", useB ? busB.done : busA.done, 1);
  endtask

  task automatic checkRun(input bit useB, input string tag, input int edges, input int wren);
    int sErr;
    checkOutput({tag, "_cycles"}, edges, 9 * mBytes);
    checkOutput({tag, "_wren_count"}, wren, mBytes);
    checkOutput({tag, "_bad_char"}, useB ? busB.bad_char : busA.bad_char, int'(mBad));
    for (int n = 0; n < mBytes; n++)
      checkOutput($sformatf("%s_out%0d", tag, n), useB ? outB[n] : outA[n], mOut[n]);
    sErr = 0;
    for (int n = 0; n < S_DEPTH; n++)
      if ((useB ? sMemB[n] : sMemA[n]) != mS[n]) sErr++;
    checkOutput({tag, "_s_final_errs"}, sErr, 0);
  endtask

  initial begin
    vec_t table1[6];
    int   edges, wren;
    int   act;

    table1[0] = '{"t1_ks0", 1'b0, 0, 8'h02};
    table1[1] = '{"t1_ks1", 1'b0, 1, 8'h05};
    table1[2] = '{"t1_ks2", 1'b0, 2, 8'h07};
    table1[3] = '{"t1_S2",  1'b1, 2, 8'h03};
    table1[4] = '{"t1_S3",  1'b1, 3, 8'h05};
    table1[5] = '{"t1_S5",  1'b1, 5, 8'h02};

    busA.start = 1'b0;
    busB.start = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle(1'b0, "reset");
    checkIdle(1'b1, "resetB");
    reset_n = 1'b1;

    $display("[TB] identity S, known keystream and 288-cycle timing");
    applyStimulus(CHECK_EN ? 1 : 0, 1'b0);
    runModel(LEN_A, CHECK_EN);
    runDut(1'b0, -1, 1'b0, edges, wren);
    checkRun(1'b0, "t1", edges, wren);
    for (int v = 0; v < 6; v++) begin
      act = table1[v].isS ? int'(snapA[table1[v].idx])
                          : int'(outA[table1[v].idx] ^ romA[table1[v].idx]);
      checkOutput(table1[v].name, act, table1[v].expected);
    end
    checkOutput("t2_cycles_288", edges, 288);
    checkOutput("t2_wren_32", wren, 32);

    $display("[TB] reset during byte 5 then rerun");
    applyStimulus(CHECK_EN ? 1 : 0, 1'b0);
    runDut(1'b0, 9 * 5 + 4, 1'b0, edges, wren);
    applyStimulus(CHECK_EN ? 1 : 0, 1'b0);
    runModel(LEN_A, CHECK_EN);
    runDut(1'b0, -1, 1'b0, edges, wren);
    checkRun(1'b0, "t3", edges, wren);

    $display("[TB] start pulses ignored mid-run");
    applyStimulus(CHECK_EN ? 1 : 0, 1'b0);
    runModel(LEN_A, CHECK_EN);
    runDut(1'b0, -1, 1'b1, edges, wren);
    checkRun(1'b0, "t4", edges, wren);
    checkOutput("t4_cycles_288", edges, 288);

    $display("[TB] plaintext 0x00 in byte 0");
    applyStimulus(3, 1'b0);
    runModel(LEN_A, CHECK_EN);
    runDut(1'b0, -1, 1'b0, edges, wren);
    checkRun(1'b0, "t5", edges, wren);
    checkOutput("t5_cycles", edges, CHECK_EN ? 9 : 288);
    checkOutput("t5_bad_char", busA.bad_char, CHECK_EN ? 1 : 0);

    $display("[TB] randomized S and ciphertext");
    for (int r = 0; r < 4; r++) begin
      applyStimulus((r % 2 == 0) ? 2 : 1, 1'b1);
      runModel(LEN_A, CHECK_EN);
      runDut(1'b0, -1, 1'b0, edges, wren);
      checkRun(1'b0, $sformatf("rnd%0d", r), edges, wren);
    end

    $display("[TB] 512-byte message with i wrap");
    applyStimulus(CHECK_EN ? 1 : 0, 1'b0);
    runModel(LEN_B, CHECK_EN);
    runDut(1'b1, -1, 1'b0, edges, wren);
    checkRun(1'b1, "t6", edges, wren);
    checkOutput("t6_cycles_4608", edges, 4608);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
